display_scan_controller: RTL

//  Time-multiplexes one shared seven-segment decoder between two common-anode digits (ones, tens) of the BCD counter display.

---
 rtl/display_pkg.sv | 22 ++
 rtl/display_scan_controller_if.sv | 23 ++
 rtl/scan_timer.sv | 37 +++
 rtl/display_scan_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit display scan controller.
package display_pkg;

  // Scan sequence: dark gap, ones digit, dark gap, tens digit.
  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    DIG0   = 2'd1,
    BLANK1 = 2'd2,
    DIG1   = 2'd3
  } scan_state_t;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [1:0] ANODE_OFF   = 2'b11;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  // A digit is kept dark when its code is not BCD, or when it is a zero that
  // the caller wants suppressed (leading-zero blanking of the tens digit).
  function automatic logic digit_dark(input logic [3:0] value, input logic blank_zero);
    return (value > BCD_MAX) || (blank_zero && (value == 4'd0));
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Update handshake carrying a new ones/tens digit pair into the scan controller.
interface display_scan_controller_if;

  logic       upd_valid;
  logic       upd_ready;
  logic [3:0] ones_in;
  logic [3:0] tens_in;

  modport master (
    output upd_valid,
    output ones_in,
    output tens_in,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  ones_in,
    input  tens_in,
    output upd_ready
  );

endinterface

// File: rtl/scan_timer.sv
// Slot counter: counts cycles within the current scan state and flags the last one.
module scan_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  // Done marks the final cycle of a slot; the owner clears the count on it.
  assign done = run && (count_q == terminal);

  // Next count: clear wins over advance.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Two-digit common-anode scan controller sharing one seven-segment decoder.
// New digit pairs are shadowed and only take effect at frame boundaries.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned LZ_BLANK     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  display_scan_controller_if.slave         upd,
  output logic [3:0]                       dec_bcd,
  output logic [1:0]                       an_n,
  output logic                             frame_tick,
  output logic                             bcd_err
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] BlankTerm = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DigTerm   = CntW'(REFRESH_DIV - BLANK_CYCLES - 1);

  scan_state_t state_q, state_d;

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] pend_ones_q, pend_ones_d;
  logic [3:0] pend_tens_q, pend_tens_d;
  logic       pending_q, pending_d;
  logic [3:0] dec_bcd_q, dec_bcd_d;
  logic [1:0] an_n_q, an_n_d;
  logic       frame_tick_q, frame_tick_d;
  logic       bcd_err_q, bcd_err_d;

  logic [CntW-1:0] slot_term;
  logic            slot_done;
  logic            slot_clear;
  logic            xfer;
  logic            boundary;
  logic            apply;
  logic            ones_dark, tens_dark;
  logic [3:0]      ones_code, tens_code;

  assign upd.upd_ready = !pending_q;
  assign dec_bcd       = dec_bcd_q;
  assign an_n          = an_n_q;
  assign frame_tick    = frame_tick_q;
  assign bcd_err       = bcd_err_q;

  // Counter restarts on every state change, including the forced return to BLANK0.
  assign slot_clear = slot_done || !en;

  scan_timer #(
    .WIDTH (CntW)
  ) u_scan_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (en),
    .clear    (slot_clear),
    .terminal (slot_term),
    .done     (slot_done)
  );

  // Scan FSM next state; disabling forces a restart from a full blank.
  always_comb begin
    state_d   = state_q;
    slot_term = DigTerm;
    if ((state_q == BLANK0) || (state_q == BLANK1)) begin
      slot_term = BlankTerm;
    end
    if (!en) begin
      state_d = BLANK0;
    end else if (slot_done) begin
      unique case (state_q)
        BLANK0:  state_d = DIG0;
        DIG0:    state_d = BLANK1;
        BLANK1:  state_d = DIG1;
        DIG1:    state_d = BLANK0;
        default: state_d = BLANK0;
      endcase
    end
  end

  // Handshake and shadow registers; pending values land only on a frame
  // boundary, or immediately while the display is disabled.
  always_comb begin
    xfer         = upd.upd_valid && !pending_q;
    boundary     = en && (state_q == DIG1) && slot_done;
    apply        = pending_q && (boundary || !en);
    pend_ones_d  = pend_ones_q;
    pend_tens_d  = pend_tens_q;
    pending_d    = pending_q;
    ones_d       = ones_q;
    tens_d       = tens_q;
    bcd_err_d    = bcd_err_q;
    frame_tick_d = boundary;
    if (xfer) begin
      pend_ones_d = upd.ones_in;
      pend_tens_d = upd.tens_in;
      pending_d   = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
    if (apply) begin
      ones_d    = pend_ones_q;
      tens_d    = pend_tens_q;
      bcd_err_d = bcd_err_q || (pend_ones_q > BCD_MAX) || (pend_tens_q > BCD_MAX);
    end
  end

  // Registered display outputs for the state being entered; blank slots preload
  // the decoder with the code of the digit that follows.
  always_comb begin
    ones_dark = digit_dark(ones_d, 1'b0);
    tens_dark = digit_dark(tens_d, LZ_BLANK != 0);
    ones_code = ones_dark ? DIGIT_BLANK : ones_d;
    tens_code = tens_dark ? DIGIT_BLANK : tens_d;
    an_n_d    = ANODE_OFF;
    dec_bcd_d = DIGIT_BLANK;
    if (en) begin
      unique case (state_d)
        BLANK0: dec_bcd_d = ones_code;
        DIG0: begin
          dec_bcd_d = ones_code;
          an_n_d    = {1'b1, ones_dark};
        end
        BLANK1: dec_bcd_d = tens_code;
        DIG1: begin
          dec_bcd_d = tens_code;
          an_n_d    = {tens_dark, 1'b1};
        end
        default: dec_bcd_d = DIGIT_BLANK;
      endcase
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK0;
      ones_q       <= 4'd0;
      tens_q       <= 4'd0;
      pend_ones_q  <= 4'd0;
      pend_tens_q  <= 4'd0;
      pending_q    <= 1'b0;
      dec_bcd_q    <= 4'h0;
      an_n_q       <= ANODE_OFF;
      frame_tick_q <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      pend_ones_q  <= pend_ones_d;
      pend_tens_q  <= pend_tens_d;
      pending_q    <= pending_d;
      dec_bcd_q    <= dec_bcd_d;
      an_n_q       <= an_n_d;
      frame_tick_q <= frame_tick_d;
      bcd_err_q    <= bcd_err_d;
    end
  end

endmodule
